// File: rtl/calendar_count.sv
// Date stage for the digital clock: day/month/four-digit year in packed BCD,
// advanced by the midnight tick or stepped by the operator. Leap years: CAL_LEAP_EN.
module calendar_count #(
    parameter logic [7:0] RST_YEAR_H = 8'h20,
    parameter logic [7:0] RST_YEAR_L = 8'h00
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       day_tick,
    input  logic       adjust,
    input  logic       add,
    input  logic [3:0] select,
    output logic [5:0] day,
    output logic [4:0] month,
    output logic [7:0] year_l,
    output logic [7:0] year_h
);

    localparam int unsigned DAY_W = 6;
    localparam int unsigned MON_W = 5;
    localparam int unsigned YR_W  = 8;
    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_DAY   = 4'd4;
    localparam logic [SEL_W-1:0] SEL_MONTH = 4'd5;
    localparam logic [SEL_W-1:0] SEL_YR_L  = 4'd6;
    localparam logic [SEL_W-1:0] SEL_YR_H  = 4'd7;

    localparam logic [DAY_W-1:0] DAY_ONE = 6'h01;
    localparam logic [MON_W-1:0] MON_ONE = 5'h01;
    localparam logic [MON_W-1:0] MON_DEC = 5'h12;

    logic             add_q;
    logic             add_p;
    logic [DAY_W-1:0] day_n;
    logic [DAY_W-1:0] day_next;
    logic [MON_W-1:0] month_n;
    logic [YR_W-1:0]  yl_n;
    logic [YR_W-1:0]  yh_n;
    logic [DAY_W-1:0] feb_cur;
    logic [DAY_W-1:0] feb_new;
    logic [DAY_W-1:0] ml_cur;
    logic [DAY_W-1:0] ml_new;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [YR_W-1:0] bcd2_inc(input logic [YR_W-1:0] v);
        logic [3:0] u;
        logic [3:0] t;
        u = v[3:0];
        t = v[7:4];
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd9) ? 4'd0 : 4'(t + 4'd1);
        end else begin
            u = 4'(u + 4'd1);
        end
        return {t, u};
    endfunction

    function automatic logic [DAY_W-1:0] day_inc(input logic [DAY_W-1:0] v);
        if (v[3:0] == 4'd9)
            return {2'(v[5:4] + 2'd1), 4'd0};
        return {v[5:4], 4'(v[3:0] + 4'd1)};
    endfunction

    // Month increment, 12 wraps to 01.
    function automatic logic [MON_W-1:0] month_inc(input logic [MON_W-1:0] v);
        if (v == MON_DEC)
            return MON_ONE;
        if (v[3:0] == 4'd9)
            return 5'h10;
        return {v[4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0] m,
                                                    input logic [DAY_W-1:0] feb);
        case (m)
            5'h02:                      return feb;
            5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
            default:                    return 6'h31;
        endcase
    endfunction

`ifdef CAL_LEAP_EN
    // Divisibility by 4 read straight off the BCD digits.
    function automatic logic bcd_div4(input logic [YR_W-1:0] v);
        if (v[4])
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic is_leap(input logic [YR_W-1:0] yl, input logic [YR_W-1:0] yh);
        if (yl != 8'h00)
            return bcd_div4(yl);
        return bcd_div4(yh);
    endfunction
`endif

    assign add_p = add & ~add_q;

    // February length for the current and for the post-update year.
    always_comb begin
`ifdef CAL_LEAP_EN
        feb_cur = is_leap(year_l, year_h) ? 6'h29 : 6'h28;
        feb_new = is_leap(yl_n, yh_n) ? 6'h29 : 6'h28;
`else
        feb_cur = 6'h28;
        feb_new = 6'h28;
`endif
        ml_cur = month_len(month, feb_cur);
        ml_new = month_len(month_n, feb_new);
    end

    // Mode is the live adjust level: run advances on tick, adjust steps on add edge.
    always_comb begin
        day_n   = day;
        month_n = month;
        yl_n    = year_l;
        yh_n    = year_h;
        if (!adjust) begin
            if (day_tick) begin
                if (day < ml_cur) begin
                    day_n = day_inc(day);
                end else begin
                    day_n = DAY_ONE;
                    if (month == MON_DEC) begin
                        month_n = MON_ONE;
                        yl_n    = bcd2_inc(year_l);
                        if (year_l == 8'h99)
                            yh_n = bcd2_inc(year_h);
                    end else begin
                        month_n = month_inc(month);
                    end
                end
            end
        end else if (add_p) begin
            case (select)
                SEL_DAY:   day_n   = (day >= ml_cur) ? DAY_ONE : day_inc(day);
                SEL_MONTH: month_n = month_inc(month);
                SEL_YR_L:  yl_n    = bcd2_inc(year_l);
                SEL_YR_H:  yh_n    = bcd2_inc(year_h);
                default:   ;
            endcase
        end
        // Clamp day into the length of the (possibly new) month/year.
        day_next = (day_n > ml_new) ? ml_new : day_n;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            day    <= DAY_ONE;
            month  <= MON_ONE;
            year_l <= RST_YEAR_L;
            year_h <= RST_YEAR_H;
            add_q  <= 1'b0;
        end else begin
            day    <= day_next;
            month  <= month_n;
            year_l <= yl_n;
            year_h <= yh_n;
            add_q  <= add;
        end
    end

endmodule

// File: tb/tb_calendar_count.sv
// Bench for calendar_count: vector table, directed corner sequences and random
// stimulus against an integer calendar model. Honours CAL_LEAP_EN.
module tb_calendar_count;

    logic       clk = 1'b0;
    logic       clr;
    logic       day_tick;
    logic       adjust;
    logic       add;
    logic [3:0] select;
    logic [5:0] day;
    logic [4:0] month;
    logic [7:0] year_l;
    logic [7:0] year_h;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers.
    int md, mm, my;
    bit madd_q;

    calendar_count dut (
        .clk(clk), .clr(clr), .day_tick(day_tick), .adjust(adjust),
        .add(add), .select(select), .day(day), .month(month),
        .year_l(year_l), .year_h(year_h)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y, m, d;
        int ticks;
        int ey, em, ed;
    } vec_t;

    function automatic int ml(input int m, input int y);
        bit leap;
`ifdef CAL_LEAP_EN
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
        leap = 1'b0;
`endif
        case (m)
            2:             return leap ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic logic [26:0] pack(input int y, input int m, input int d);
        return {2'(d / 10), 4'(d % 10), 1'(m / 10), 4'(m % 10),
                4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
    endfunction

    function automatic logic [26:0] dut_date();
        return {day, month, year_h, year_l};
    endfunction

    task automatic check(input string name, input logic [26:0] exp);
        checks++;
        if (dut_date() !== exp) begin
            errors++;
            $display("FAIL %s: got d/m/yh/yl %h/%h/%h%h, expected %h/%h/%h%h", name,
                     day, month, year_h, year_l, exp[26:21], exp[20:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic model_reset();
        md = 1; mm = 1; my = 2000; madd_q = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit a, input bit ad, input int s);
        bit ap;
        ap = ad && !madd_q;
        madd_q = ad;
        if (!a) begin
            if (t) begin
                if (md < ml(mm, my)) md++;
                else begin
                    md = 1;
                    if (mm == 12) begin
                        mm = 1;
                        my = (my + 1) % 10000;
                    end else mm++;
                end
            end
        end else if (ap) begin
            case (s)
                4: md = (md >= ml(mm, my)) ? 1 : md + 1;
                5: mm = mm % 12 + 1;
                6: my = (my / 100) * 100 + (my % 100 + 1) % 100;
                7: my = ((my / 100 + 1) % 100) * 100 + my % 100;
                default: ;
            endcase
            if (md > ml(mm, my)) md = ml(mm, my);
        end
    endtask

    task automatic cycle(input bit t, input bit a, input bit ad, input int s);
        @(negedge clk);
        day_tick = t;
        adjust   = a;
        add      = ad;
        select   = 4'(s);
        model_step(t, a, ad, s);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, 1, s);
            cycle(0, 1, 0, s);
        end
    endtask

    // Walk the fields in adjust mode: century, year, month, then day last.
    task automatic set_date(input int y, input int m, input int d);
        press(7, ((y / 100) - (my / 100) + 100) % 100);
        press(6, ((y % 100) - (my % 100) + 100) % 100);
        press(5, (m - mm + 12) % 12);
        press(4, (d - md + ml(mm, my)) % ml(mm, my));
        check("set_date", pack(my, mm, md));
    endtask

    vec_t vecs[$];

    initial begin
        clr = 1'b1; day_tick = 0; adjust = 0; add = 0; select = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack(2000, 1, 1));
        @(negedge clk);
        clr = 1'b0;

        // Vector table: start date, number of run-mode ticks, expected date.
`ifdef CAL_LEAP_EN
        vecs.push_back('{2024, 2, 28, 1, 2024, 2, 29});
        vecs.push_back('{2024, 2, 28, 2, 2024, 3, 1});
        vecs.push_back('{2023, 2, 28, 1, 2023, 3, 1});
        vecs.push_back('{2000, 2, 28, 1, 2000, 2, 29});
        vecs.push_back('{2100, 2, 28, 1, 2100, 3, 1});
`else
        vecs.push_back('{2024, 2, 28, 1, 2024, 3, 1});
        vecs.push_back('{2000, 2, 28, 1, 2000, 3, 1});
`endif
        vecs.push_back('{2099, 12, 31, 1, 2100, 1, 1});
        vecs.push_back('{9999, 12, 31, 1, 0, 1, 1});
        vecs.push_back('{2023, 1, 31, 1, 2023, 2, 1});
        vecs.push_back('{2023, 4, 30, 2, 2023, 5, 2});
        vecs.push_back('{1999, 9, 9, 1, 1999, 9, 10});
        foreach (vecs[i]) begin
            set_date(vecs[i].y, vecs[i].m, vecs[i].d);
            for (int k = 0; k < vecs[i].ticks; k++) cycle(1, 0, 0, 0);
            check($sformatf("vec%0d", i), pack(vecs[i].ey, vecs[i].em, vecs[i].ed));
        end

        // Month step clamps 31 Jan to end of February.
        set_date(2023, 1, 31);
        press(5, 1);
        check("clamp_month", pack(2023, 2, 28));
        press(6, 1);
        press(4, 1);
`ifdef CAL_LEAP_EN
        check("set_feb29", pack(2024, 2, 29));
        press(6, 1);
        check("clamp_year", pack(2025, 2, 28));
`else
        check("feb_wrap", pack(2024, 2, 1));
        press(6, 1);
        check("year_step", pack(2025, 2, 1));
`endif

        // Held add gives one step; ticks dropped in adjust; add ignored in run.
        set_date(2023, 3, 10);
        repeat (5) cycle(0, 1, 1, 4);
        cycle(0, 1, 0, 4);
        check("add_held", pack(2023, 3, 11));
        cycle(1, 1, 0, 4);
        check("tick_in_adjust", pack(2023, 3, 11));
        cycle(0, 0, 1, 4);
        cycle(0, 0, 0, 4);
        check("add_in_run", pack(2023, 3, 11));
        cycle(1, 1, 0, 4);
        check("tick_on_adjust_rise", pack(2023, 3, 11));
        cycle(1, 0, 0, 4);
        check("tick_on_adjust_fall", pack(2023, 3, 12));
        cycle(0, 1, 1, 8);
        cycle(0, 1, 0, 8);
        check("bad_select", pack(2023, 3, 12));

        // Asynchronous clear between edges, then back-to-back ticks.
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        check("async_clr", pack(2000, 1, 1));
        @(negedge clk);
        day_tick = 0; adjust = 0; add = 0;
        clr = 1'b0;
        repeat (3) cycle(1, 0, 0, 0);
        check("tick_x3", pack(2000, 1, 4));

        // Random dates and random control streams against the model.
        for (int r = 0; r < 6; r++) begin
            int y, m, d;
            y = int'($urandom % 10000);
            m = 1 + int'($urandom % 12);
            d = 1 + int'($urandom % 32'(ml(m, y)));
            set_date(y, m, d);
            for (int c = 0; c < 150; c++) begin
                cycle(bit'($urandom % 2), ($urandom % 3) == 0, bit'($urandom % 2),
                      int'($urandom_range(3, 8)));
                check("random", pack(my, mm, md));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
